// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//   Registered N-input arbiter. It encodes the request vector into a binary
//   grant index and a one-hot grant, and presents the result under a
//   valid/ready handshake. It has two modes: fixed priority, where the highest
//   index wins, and round-robin, which rotates from a pointer.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = fixed priority (highest index), 1 = round-robin
//   req        in   [N-1:0] request vector, bit i = source i requesting
//   gnt_ready  in   downstream accepts the presented grant
//   gnt_valid  out  a grant is presented
//   gnt_idx    out  [W-1:0] binary index of the granted source
//   gnt_onehot out  [N-1:0] one-hot form of gnt_idx, zero when not valid
//
// States
//   IDLE  | no grant presented, waiting for any request
//   GRANT | grant presented and held until the handshake

module rr_priority_arbiter #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] onehot_q, onehot_d;

  logic         req_any;
  logic         handshake;
  logic [W-1:0] ptr_adv;
  logic [W-1:0] rr_base;
  logic [W-1:0] fixed_win;
  logic [W-1:0] rr_win;
  logic [W-1:0] winner;
  logic [N-1:0] winner_onehot;

  // An X on req reduces to X here. The IDLE branch below then does not take
  // the grant path, so X requests cannot raise gnt_valid.
  assign req_any   = |req;
  assign handshake = (state_q == GRANT) && gnt_ready;

  // The pointer moves past the source that is being accepted. The wrap uses
  // an explicit compare so that non-power-of-two N stays inside 0..N-1.
  always_comb begin
    ptr_adv = '0;
    if (idx_q != W'(N - 1)) begin
      ptr_adv = idx_q + W'(1);
    end
  end

  // A back-to-back round-robin decision searches from the pointer that this
  // same handshake is about to write.
  assign rr_base = (handshake && mode) ? ptr_adv : ptr_q;

  always_comb begin
    fixed_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        fixed_win = W'(i);
      end
    end
  end

  // Round-robin: the winner is the set bit at the smallest circular distance
  // above rr_base. Every req bit is compared with a constant index. This
  // avoids a variable-position select.
  always_comb begin
    int d;
    int best_d;
    rr_win = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (i >= int'(rr_base)) begin
          d = i - int'(rr_base);
        end else begin
          d = i + N - int'(rr_base);
        end
        if (d < best_d) begin
          best_d = d;
          rr_win = W'(i);
        end
      end
    end
  end

  assign winner = mode ? rr_win : fixed_win;

  always_comb begin
    winner_onehot = '0;
    for (int i = 0; i < N; i++) begin
      winner_onehot[i] = (winner == W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = GRANT;
          idx_d    = winner;
          onehot_d = winner_onehot;
        end
      end
      GRANT: begin
        // Without gnt_ready the presented grant stays frozen. It is held
        // through request drops, new higher-priority requests and mode
        // changes.
        if (gnt_ready) begin
          if (mode) begin
            ptr_d = ptr_adv;
          end
          if (req_any) begin
            idx_d    = winner;
            onehot_d = winner_onehot;
          end else begin
            state_d  = IDLE;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised, registered successor to the 4-to-2 combinational priority encoder.
- Encodes N request lines into a binary grant index and a one-hot grant.
- Two runtime-selectable modes: fixed priority, with the highest index winning as in the 4-to-2 encoder, and round-robin.
- Grants are issued under a valid/ready handshake. Used wherever several sources share one downstream sink.

Parameters:
- N, 8, number of request lines; legal range 1..64.
- W, $clog2(N) with a minimum of 1, index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- req  input  N  request vector; bit i = source i requesting.
- gnt_ready  input  1  downstream accepts the current grant.
- gnt_valid  output  1  a grant is presented.
- gnt_idx  output  W  binary index of the granted source.
- gnt_onehot  output  N  one-hot form of gnt_idx; all zero when gnt_valid=0.

Behaviour:
- One clock domain. Reset is asynchronous and active-low:
  - rst_n=0 immediately forces gnt_valid=0, gnt_idx=0, gnt_onehot=0, round-robin pointer ptr=0, state IDLE.
  - Release is taken on the next clk edge.
- All outputs are driven directly from flops; no combinational path from req to any output.
- States:
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1.
- Latency: req sampled non-zero at edge k gives gnt_valid=1 after edge k, i.e. during cycle k+1.
- Transitions:
  - IDLE, req!=0: compute winner, register gnt_idx/gnt_onehot, go to GRANT.
  - IDLE, req==0: stay in IDLE. Equivalent of the 4-to-2 encoder's valid=0 output.
  - GRANT, gnt_ready=0: hold gnt_idx/gnt_onehot stable. Holds even if the granted req bit drops or a higher-priority req arrives; grants are never withdrawn.
  - GRANT, gnt_ready=1 (handshake), req!=0 at that edge: register the new winner and stay in GRANT. Sustained throughput is one grant per cycle.
  - GRANT, gnt_ready=1, req==0: go to IDLE and clear gnt_onehot.
- Winner selection:
  - Evaluated from req and mode sampled at the issuing edge only.
  - Fixed mode: highest set index wins.
  - Round-robin mode:
    - Search ascending from ptr, wrapping N-1 to 0; first set bit wins.
    - ptr updates only on handshake in round-robin mode, to (granted index + 1) mod N. Wrap uses an explicit compare, not power-of-two truncation, since N need not be a power of 2.
    - The back-to-back winner at a handshake edge uses the updated ptr.
- ptr is held, not cleared, while in fixed mode, so a mode switch resumes rotation where it left off.
- A mode change while in GRANT does not affect the presented grant.
- N=1: gnt_idx is always 0; behaviour is valid/ready passthrough with 1-cycle latency.
- X on req while in IDLE must not propagate: gnt_valid must stay 0 if req==0.

Test Plan:
- Reset mid-grant: N=8, GRANT with gnt_idx=5, pull rst_n low between edges → gnt_valid, gnt_idx, gnt_onehot are 0 before the next edge; after release, req=0x01 gives gnt_idx=0 one cycle later.
- Fixed priority: mode=0, req=8'b0100_1010, gnt_ready=1 → gnt_idx=6, gnt_onehot=0x40 every cycle while req is held. req=0x00 → gnt_valid=0 after the next edge.
- Round-robin sweep: mode=1, req=0xFF, gnt_ready=1 from reset → gnt_idx sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles, no bubbles.
- Backpressure: req=0x10 → gnt_idx=4. Hold gnt_ready=0 for 3 cycles while req changes to 0x81 → gnt_idx stays 4 and gnt_valid stays 1. Then gnt_ready=1 → next grant 7 in fixed mode, or 7 in round-robin mode with ptr=5.
- Round-robin sparse wrap: mode=1, ptr=7 after granting 6, req=0x41 → next grant 0, then 6, then 0, alternating.
- Non-power-of-two: N=5, mode=1, req=5'b11111 → grants 0,1,2,3,4,0. ptr never reaches 5 or above; gnt_idx stays within 0..4.
